edge_period_meter: RTL and testbench



---
 rtl/edge_period_meter_pkg.sv | 21 ++
 rtl/edge_period_meter_if.sv | 25 ++
 rtl/edge_period_meter_sync_fifo_fwft.sv | 66 ++++++
 rtl/edge_period_meter.sv | 89 ++++++++
 tb/tb_edge_period_meter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/edge_period_meter_pkg.sv
// Shared types and constants for the edge period meter.
// Holds the FSM encoding, the default count width and a constant-safe clog2.
package edge_period_meter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_e;

   localparam int DEFAULT_CNT_W = 16;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/edge_period_meter_if.sv
// Consumer-facing side of the period meter: FWFT head, occupancy and drop flag.
// The meter drives through the master modport, the consumer uses the slave modport.
interface edge_period_meter_if #(
   parameter int CNT_W = edge_period_meter_pkg::DEFAULT_CNT_W,
   parameter int DEPTH = 4
) ();
   localparam int LW = edge_period_meter_pkg::clog2(DEPTH) + 1;

   logic [CNT_W-1:0] PERIOD_OUT;
   logic             SAT_OUT;
   logic             VALID_OUT;
   logic             READY_IN;
   logic [LW-1:0]    LEVEL_OUT;
   logic             DROP_OUT;

   modport master (
      output PERIOD_OUT, SAT_OUT, VALID_OUT, LEVEL_OUT, DROP_OUT,
      input  READY_IN
   );

   modport slave (
      input  PERIOD_OUT, SAT_OUT, VALID_OUT, LEVEL_OUT, DROP_OUT,
      output READY_IN
   );
endinterface

// File: rtl/edge_period_meter_sync_fifo_fwft.sv
// First-word-fall-through FIFO: a push is visible at the head on the next cycle.
// Full/empty come from the level counter; a push while full is accepted only alongside a pop.
module sync_fifo_fwft
   import edge_period_meter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_dat_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_dat_o,
   output logic                     head_vld_o,
   output logic [clog2(DEPTH):0]    level_o
);
   localparam int AW = clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             full, empty, do_push, do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_pop  = pop_i && !empty;
   assign do_push = push_i && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign head_vld_o = !empty;
   assign head_dat_o = empty ? '0 : mem_q[rd_ptr_q];
   assign level_o    = level_q;

endmodule

// File: rtl/edge_period_meter.sv
// Counts SYNC_CLK_IN cycles between detect pulses and queues each saturating period.
// The first pulse after reset only arms the counter; overflowing pushes set a sticky drop flag.
module edge_period_meter
   import edge_period_meter_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W,
   parameter int DEPTH = 4
) (
   input  logic               SYNC_CLK_IN,
   input  logic               RESET_IN,
   input  logic               DETECT_IN,
   edge_period_meter_if.master out_if
);
   localparam int LW = clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             drop_q, drop_d;
   logic [CNT_W:0]   cnt_p1;
   logic             sat;
   logic [CNT_W-1:0] period;
   logic             push, pop, full;
   logic [CNT_W:0]   head_dat;
   logic             head_vld;
   logic [LW-1:0]    level;

   // One extra bit keeps cnt+1 exact so saturation is decided before truncation.
   assign cnt_p1 = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign sat    = (cnt_p1 >= {1'b0, CNT_MAX});
   assign period = sat ? CNT_MAX : cnt_p1[CNT_W-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (DETECT_IN) state_d = ARMED;
         end
         ARMED: begin
            if (DETECT_IN) begin
               push  = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = period;
            end
         end
      endcase
   end

   assign pop    = head_vld && out_if.READY_IN;
   assign full   = (level == LW'(DEPTH));
   assign drop_d = drop_q | (push & full & ~pop);

   always_ff @(posedge SYNC_CLK_IN) begin
      if (RESET_IN) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (CNT_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i      (SYNC_CLK_IN),
      .rst_i      (RESET_IN),
      .push_i     (push),
      .push_dat_i ({sat, period}),
      .pop_i      (pop),
      .head_dat_o (head_dat),
      .head_vld_o (head_vld),
      .level_o    (level)
   );

   assign out_if.PERIOD_OUT = head_dat[CNT_W-1:0];
   assign out_if.SAT_OUT    = head_dat[CNT_W];
   assign out_if.VALID_OUT  = head_vld;
   assign out_if.LEVEL_OUT  = level;
   assign out_if.DROP_OUT   = drop_q;

endmodule

// File: tb/tb_edge_period_meter.sv
// Bench for edge_period_meter (CNT_W=8, DEPTH=4): vector table, directed sequences
// and a randomized run, all compared each cycle against a timestamp-based queue model.
module tb_edge_period_meter;
   localparam int CNT_W = 8;
   localparam int DEPTH = 4;
   localparam int PMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic RESET_IN = 1'b1;
   logic DETECT_IN = 1'b0;

   edge_period_meter_if #(.CNT_W(CNT_W), .DEPTH(DEPTH)) bus ();

   edge_period_meter #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .SYNC_CLK_IN (clk),
      .RESET_IN    (RESET_IN),
      .DETECT_IN   (DETECT_IN),
      .out_if      (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: timestamps of pulses, a queue of entries, sticky drop.
   typedef struct {
      int per;
      bit sat;
   } ent_t;
   ent_t mq[$];
   bit   m_armed = 0;
   bit   m_drop = 0;
   int   m_now = 0;
   int   m_last = 0;

   typedef struct {
      logic det, rdy, rst;
      logic vld;
      int   per;
      logic sat;
      int   lvl;
      logic drp;
   } vec_t;
   vec_t tbl[15];

   function automatic vec_t mk(logic det, logic rdy, logic rst, logic vld, int per,
                               logic sat, int lvl, logic drp);
      vec_t v;
      v.det = det; v.rdy = rdy; v.rst = rst;
      v.vld = vld; v.per = per; v.sat = sat; v.lvl = lvl; v.drp = drp;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_update(input logic det, input logic rdy, input logic rst);
      bit   pop, push;
      int   gap;
      ent_t e;
      m_now++;
      if (rst) begin
         m_armed = 0;
         m_drop  = 0;
         mq.delete();
         return;
      end
      pop  = (mq.size() > 0) && rdy;
      push = m_armed && det;
      if (det && !m_armed) begin
         m_armed = 1;
         m_last  = m_now;
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
         gap    = m_now - m_last;
         m_last = m_now;
         e.per  = (gap > PMAX) ? PMAX : gap;
         e.sat  = (gap >= PMAX);
         if (mq.size() < DEPTH) mq.push_back(e);
         else m_drop = 1;
      end
   endtask

   task automatic step(input logic det, input logic rdy, input logic rst);
      DETECT_IN    = det;
      bus.READY_IN = rdy;
      RESET_IN     = rst;
      @(posedge clk);
      model_update(det, rdy, rst);
      #1;
      check("model.valid", bus.VALID_OUT, (mq.size() > 0) ? 1 : 0);
      check("model.period", bus.PERIOD_OUT, (mq.size() > 0) ? mq[0].per : 0);
      check("model.sat", bus.SAT_OUT, (mq.size() > 0) ? mq[0].sat : 0);
      check("model.level", bus.LEVEL_OUT, mq.size());
      check("model.drop", bus.DROP_OUT, m_drop);
   endtask

   task automatic do_reset();
      step(0, 0, 1);
      step(0, 0, 1);
   endtask

   task automatic head_is(input string nm, input logic vld, input int per, input logic sat);
      check({nm, ".valid"}, bus.VALID_OUT, vld);
      check({nm, ".period"}, bus.PERIOD_OUT, per);
      check({nm, ".sat"}, bus.SAT_OUT, sat);
   endtask

   initial begin
      bus.READY_IN = 1'b0;
      @(posedge clk);
      #1;
      do_reset();
      head_is("reset", 0, 0, 0);
      check("reset.level", bus.LEVEL_OUT, 0);
      check("reset.drop", bus.DROP_OUT, 0);

      // Table: back-to-back pulses, full push+pop, overflow drop, mid-run reset.
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 0, 0, 1, 1, 0, 1, 0);
      tbl[2]  = mk(1, 0, 0, 1, 1, 0, 2, 0);
      tbl[3]  = mk(0, 0, 0, 1, 1, 0, 2, 0);
      tbl[4]  = mk(1, 0, 0, 1, 1, 0, 3, 0);
      tbl[5]  = mk(1, 0, 0, 1, 1, 0, 4, 0);
      tbl[6]  = mk(1, 1, 0, 1, 1, 0, 4, 0);
      tbl[7]  = mk(0, 1, 0, 1, 2, 0, 3, 0);
      tbl[8]  = mk(0, 0, 0, 1, 2, 0, 3, 0);
      tbl[9]  = mk(1, 0, 0, 1, 2, 0, 4, 0);
      tbl[10] = mk(1, 0, 0, 1, 2, 0, 4, 1);
      tbl[11] = mk(1, 0, 1, 0, 0, 0, 0, 0);
      tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0);
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0);
      tbl[14] = mk(1, 0, 0, 1, 2, 0, 1, 0);
      for (int i = 0; i < 15; i++) begin
         step(tbl[i].det, tbl[i].rdy, tbl[i].rst);
         head_is($sformatf("tbl[%0d]", i), tbl[i].vld, tbl[i].per, tbl[i].sat);
         check($sformatf("tbl[%0d].level", i), bus.LEVEL_OUT, tbl[i].lvl);
         check($sformatf("tbl[%0d].drop", i), bus.DROP_OUT, tbl[i].drp);
      end

      // Pulses at cycles 10, 30, 35 with the consumer always ready.
      do_reset();
      for (int c = 1; c <= 40; c++) begin
         step((c == 10 || c == 30 || c == 35), 1, 0);
         if (c == 10) check("seq1.arm_level", bus.LEVEL_OUT, 0);
         if (c == 30) head_is("seq1.p20", 1, 20, 0);
         if (c == 31) check("seq1.popped", bus.VALID_OUT, 0);
         if (c == 35) head_is("seq1.p5", 1, 5, 0);
      end

      // Saturation: 300-cycle gap, then a 7-cycle gap.
      do_reset();
      step(1, 1, 0);
      repeat (299) step(0, 1, 0);
      step(1, 1, 0);
      head_is("seq2.sat", 1, PMAX, 1);
      repeat (6) step(0, 1, 0);
      step(1, 1, 0);
      head_is("seq2.p7", 1, 7, 0);

      // Overflow with consumer stalled, then drain in order.
      do_reset();
      step(1, 0, 0);
      for (int p = 1; p <= 6; p++) begin
         repeat (9) step(0, 0, 0);
         step(1, 0, 0);
         if (p == 4) begin
            check("seq3.full_level", bus.LEVEL_OUT, 4);
            check("seq3.no_drop_yet", bus.DROP_OUT, 0);
         end
         if (p == 5) check("seq3.drop", bus.DROP_OUT, 1);
      end
      for (int k = 0; k < 4; k++) begin
         head_is($sformatf("seq3.drain%0d", k), 1, 10, 0);
         step(0, 1, 0);
      end
      check("seq3.empty", bus.VALID_OUT, 0);
      check("seq3.drop_sticky", bus.DROP_OUT, 1);

      // Randomized traffic with varying pulse density and consumer stalls.
      do_reset();
      for (int blk = 0; blk < 12; blk++) begin
         int rate;
         int stall;
         case ($urandom_range(0, 3))
            0: rate = 1;
            1: rate = 5;
            2: rate = 25;
            default: rate = 350;
         endcase
         stall = $urandom_range(0, 4);
         for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, rate) == 0),
                 ($urandom_range(0, 4) >= stall),
                 ($urandom_range(0, 999) == 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
